// File: rtl/operand_loader_if.sv
// operand_loader_if: switch/button/clear inputs and registered operand
// outputs of the operand entry stage, bundled for the board top and bench.
interface operand_loader_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] sw;
   logic             load_btn;
   logic             clear;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             valid;
   logic [1:0]       state;

   // Board / bench side: drives switches, button and clear; observes operands.
   modport master (
      output sw, load_btn, clear,
      input  a, b, valid, state
   );

   // Loader side: consumes switches, button and clear; drives operands.
   modport slave (
      input  sw, load_btn, clear,
      output a, b, valid, state
   );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: captures operand a, then b, from the switches on successive
// debounced presses of the load button and holds them as registered outputs
// with a valid flag for the combinational add/sub stage and its display.
module operand_loader #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16   // minimum 2
) (
   input  logic            clk,
   input  logic            rst,
   operand_loader_if.slave bus
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] WAIT_A = 2'b00;
   localparam logic [1:0] WAIT_B = 2'b01;
   localparam logic [1:0] SHOW   = 2'b10;

   logic             btn_meta;
   logic             btn_s;
   logic [WIDTH-1:0] sw_meta;
   logic [WIDTH-1:0] sw_s;

   logic             db_level;
   logic             db_level_d;
   logic [CNT_W-1:0] db_cnt;
   logic             press;

   logic [1:0]       state_q;
   logic [1:0]       state_n;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_n;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_n;
   logic             valid_q;
   logic             valid_n;

   // Two-flop synchronizers bring the asynchronous button and switches into clk.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make each stage sample its predecessor's
      // pre-edge value; blocking ones would collapse the chain into one flop.
      if (rst) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
         sw_meta  <= '0;
         sw_s     <= '0;
      end else begin
         btn_meta <= bus.load_btn;
         btn_s    <= btn_meta;
         sw_meta  <= bus.sw;
         sw_s     <= sw_meta;
      end
   end

   // Debouncer: a new button level is accepted only after DEBOUNCE_CYCLES
   // consecutive synchronized samples that differ from the current level;
   // any return to the current level restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_level <= 1'b0;
         db_cnt   <= '0;
      end else if (btn_s == db_level) begin
         db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
         db_level <= btn_s;
         db_cnt   <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // Rising-edge detector on the debounced level: one registered pulse per press.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_level_d <= 1'b0;
         press      <= 1'b0;
      end else begin
         db_level_d <= db_level;
         press      <= db_level & ~db_level_d;
      end
   end

   // Entry FSM next values: clear wins over a press; otherwise each press
   // loads a (from WAIT_A or SHOW) or b (from WAIT_B).
   always_comb begin
      // NOTE: every variable is given its hold value first so no branch leaves
      // it unassigned, which would otherwise infer a latch.
      state_n = state_q;
      a_n     = a_q;
      b_n     = b_q;
      valid_n = valid_q;
      if (bus.clear) begin
         state_n = WAIT_A;
         a_n     = '0;
         b_n     = '0;
         valid_n = 1'b0;
      end else if (press) begin
         case (state_q)
            WAIT_A: begin
               a_n     = sw_s;
               state_n = WAIT_B;
            end
            WAIT_B: begin
               b_n     = sw_s;
               valid_n = 1'b1;
               state_n = SHOW;
            end
            SHOW: begin
               a_n     = sw_s;
               valid_n = 1'b0;
               state_n = WAIT_B;
            end
            default: begin
               // Unused encoding: fall back to a clean start.
               valid_n = 1'b0;
               state_n = WAIT_A;
            end
         endcase
      end
   end

   // Entry FSM and operand registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_A;
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_n;
         a_q     <= a_n;
         b_q     <= b_n;
         valid_q <= valid_n;
      end
   end

   assign bus.a     = a_q;
   assign bus.b     = b_q;
   assign bus.valid = valid_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: randomized stimulus with a scoreboard. Stimulus tasks
// push the expected output update (with the edge it must land on) into a
// queue; a monitor pops and compares each time the outputs change.
module tb_operand_loader;

   localparam int WIDTH = 4;
   localparam int D     = 4;

   typedef struct {
      int               edge_no;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             valid;
      logic [1:0]       state;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;

   exp_t             exp_q[$];
   exp_t             last_exp;
   logic [WIDTH-1:0] caps[$];   // switch values captured since last clear/reset

   operand_loader_if #(.WIDTH(WIDTH)) bus ();

   operand_loader #(
      .WIDTH(WIDTH),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference model: presses since the last clear alternate a, b, a, b...
   // a shows the latest odd-numbered capture, b the latest even-numbered one.
   function automatic exp_t model_out(input int edge_no);
      exp_t e;
      int   n;
      n         = caps.size();
      e.edge_no = edge_no;
      e.a       = '0;
      e.b       = '0;
      for (int i = 0; i < n; i++) begin
         if (i % 2 == 0) e.a = caps[i];
         else            e.b = caps[i];
      end
      e.valid = (n > 0) && (n % 2 == 0);
      e.state = (n == 0) ? 2'b00 : ((n % 2 == 1) ? 2'b01 : 2'b10);
      return e;
   endfunction

   task automatic push_if_changed(input int edge_no);
      exp_t e;
      e = model_out(edge_no);
      if (e.a !== last_exp.a || e.b !== last_exp.b ||
          e.valid !== last_exp.valid || e.state !== last_exp.state)
         exp_q.push_back(e);
      last_exp = e;
   endtask

   task automatic model_press(input logic [WIDTH-1:0] v, input int edge_no);
      caps.push_back(v);
      push_if_changed(edge_no);
   endtask

   task automatic model_clear(input int edge_no);
      caps.delete();
      push_if_changed(edge_no);
   endtask

   // Monitor: every output change must match the next queued expectation.
   initial begin : monitor
      logic [2*WIDTH+2:0] cur;
      logic [2*WIDTH+2:0] prev;
      exp_t               e;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {bus.a, bus.b, bus.valid, bus.state};
         if (mon_en && cur !== prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_update", int'(cur), int'(prev));
            end else begin
               e = exp_q.pop_front();
               check("update_edge", cyc, e.edge_no);
               check("a", int'(bus.a), int'(e.a));
               check("b", int'(bus.b), int'(e.b));
               check("valid", int'(bus.valid), int'(e.valid));
               check("state", int'(bus.state), int'(e.state));
            end
         end
         prev = cur;
      end
   end

   // One button press: optional bounce bursts (each high burst shorter than
   // D), then a clean hold. The update lands D+3 edges after the hold's first
   // sampling edge; optionally clear is raised exactly on that edge.
   task automatic press_event(input logic [WIDTH-1:0] v, input int bounces,
                              input int hi_max, input int lo_max,
                              input int hold, input int low,
                              input bit clear_at_update);
      int n_edge;
      @(negedge clk);
      bus.sw = v;
      repeat (3) @(negedge clk);
      for (int k = 0; k < bounces; k++) begin
         bus.load_btn = 1'b1;
         repeat ($urandom_range(1, hi_max)) @(negedge clk);
         bus.load_btn = 1'b0;
         repeat ($urandom_range(1, lo_max)) @(negedge clk);
      end
      bus.load_btn = 1'b1;
      n_edge = cyc + 1;
      if (clear_at_update) model_clear(n_edge + D + 3);
      else                 model_press(v, n_edge + D + 3);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         bus.clear = clear_at_update && (cyc == n_edge + D + 2);
      end
      bus.clear    = 1'b0;
      bus.load_btn = 1'b0;
      repeat (low) @(negedge clk);
   endtask

   task automatic glitch(input int g);
      @(negedge clk);
      bus.load_btn = 1'b1;
      repeat (g) @(negedge clk);
      bus.load_btn = 1'b0;
      repeat (D + 2) @(negedge clk);
   endtask

   task automatic clear_pulse();
      @(negedge clk);
      bus.clear = 1'b1;
      model_clear(cyc + 1);
      @(negedge clk);
      bus.clear = 1'b0;
   endtask

   // Reset pulse, optionally with the button held through reset release.
   task automatic reset_pulse(input bit hold_btn, input logic [WIDTH-1:0] v);
      @(negedge clk);
      rst = 1'b1;
      model_clear(cyc + 1);
      if (hold_btn) begin
         bus.sw       = v;
         bus.load_btn = 1'b1;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      if (hold_btn) begin
         model_press(v, cyc + 1 + D + 3);
         repeat (3 * D + 10) @(negedge clk);
         bus.load_btn = 1'b0;
         repeat (D + 2) @(negedge clk);
      end else begin
         repeat (2) @(negedge clk);
      end
   endtask

   initial begin : stimulus
      int r;
      bus.sw       = '0;
      bus.load_btn = 1'b0;
      bus.clear    = 1'b0;
      caps.delete();
      last_exp = model_out(0);

      repeat (3) @(negedge clk);
      check("reset_a", int'(bus.a), 0);
      check("reset_b", int'(bus.b), 0);
      check("reset_valid", int'(bus.valid), 0);
      check("reset_state", int'(bus.state), 0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Two clean presses: a=E, b=7, SHOW.
      press_event(4'hE, 0, 1, 1, D + 3, D + 2, 1'b0);
      press_event(4'h7, 0, 1, 1, D + 3, D + 2, 1'b0);
      // Reach SHOW with a=F, b=1, then a press with sw=0 reloads a only.
      press_event(4'hF, 0, 1, 1, D + 3, D + 2, 1'b0);
      press_event(4'h1, 0, 1, 1, D + 3, D + 2, 1'b0);
      press_event(4'h0, 0, 1, 1, D + 3, D + 2, 1'b0);
      // In WAIT_B, clear on the press cycle: zeros, press discarded.
      press_event(4'h9, 0, 1, 1, D + 5, D + 2, 1'b1);
      // Short glitch: nothing happens.
      glitch(D - 1);
      // Bounce 1,0,1,0,1,0 then hold: exactly one load.
      press_event(4'h5, 3, 1, 1, D + 3, D + 2, 1'b0);
      // Button held through reset from WAIT_B: one load after release.
      reset_pulse(1'b1, 4'hC);

      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4:
               press_event(WIDTH'($urandom), $urandom_range(0, 3), D - 1, 3,
                           $urandom_range(D, D + 6), $urandom_range(D + 2, D + 6), 1'b0);
            5:
               press_event(WIDTH'($urandom), $urandom_range(0, 2), D - 1, 3,
                           D + 4, D + 2, 1'b1);
            6, 7:
               glitch($urandom_range(1, D - 1));
            8:
               clear_pulse();
            default:
               reset_pulse(1'($urandom_range(0, 1)), WIDTH'($urandom));
         endcase
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      check("final_a", int'(bus.a), int'(last_exp.a));
      check("final_b", int'(bus.b), int'(last_exp.b));
      check("final_valid", int'(bus.valid), int'(last_exp.valid));
      check("final_state", int'(bus.state), int'(last_exp.state));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
